// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, one word per valid/ready handshake.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// Each bit lasts OVERSAMPLE baud_tick pulses.
// Optional macro UART_TX_BREAK_EN adds a tx_break input that holds the line low from IDLE.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   baud_tick       one-clk oversample strobe from the baud generator
//   tx_valid        host has a word to send
//   tx_data         word to send, sampled only on handshake
//   tx_break        (UART_TX_BREAK_EN only) request a line break
//   tx_ready        block can accept a word
//   tx              serial line, idle high, registered
//   busy            state machine is not IDLE
module uart_tx_frame #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
        , BRK, BRK_REC
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;

    assign bit_end  = baud_tick && tick_q == CW'(OVERSAMPLE - 1);
    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        tick_d  = (state_q == IDLE || bit_end) ? '0 : tick_q + CW'(baud_tick);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid && ready_q) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                else if (tx_break) begin
                    state_d = BRK;
                    tx_d    = 1'b0;
                end
`endif
            end
            START: if (bit_end) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 4'd1;
                tx_d    = shift_q[1];
                if (bit_q == 4'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    tx_d    = (PARITY_MODE != 0) ? par_q : 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (bit_end) begin
                state_d = (bit_q == 4'(STOP_BITS - 1)) ? IDLE : STOP;
                bit_d   = (bit_q == 4'(STOP_BITS - 1)) ? 4'd0 : bit_q + 4'd1;
            end
`ifdef UART_TX_BREAK_EN
            // Line held low until release, then one idle-high bit time before accepting again.
            BRK: begin
                tick_d  = '0;
                tx_d    = tx_break ? 1'b0 : 1'b1;
                state_d = tx_break ? BRK : BRK_REC;
            end
            BRK_REC: if (bit_end) state_d = IDLE;
`endif
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized self-checking bench for three uart_tx_frame configurations.
// u0: 8N1 oversample 16; u1: 7 bits even parity 2 stop; u2: 9 bits odd parity 1 stop oversample 3.
// Expected line levels come from a bit-list frame model indexed by ticks seen since accept.
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst, bt;
    logic       tv [3];
    logic [7:0] td0;
    logic [6:0] td1;
    logic [8:0] td2;
    logic       txo [3], rdy [3], bsy [3];
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif
    int db [3] = '{8, 7, 9};
    int os [3] = '{16, 16, 3};
    int pm [3] = '{0, 1, 2};
    int sb [3] = '{1, 2, 1};
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_frame u0 (
        .clk(clk), .rst(rst), .baud_tick(bt), .tx_valid(tv[0]), .tx_data(td0),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));

    uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .baud_tick(bt), .tx_valid(tv[1]), .tx_data(td1),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));

    uart_tx_frame #(.DATA_BITS(9), .OVERSAMPLE(3), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(bt), .tx_valid(tv[2]), .tx_data(td2),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(int k, logic v, int w);
        tv[k] = v;
        case (k)
            0: td0 = w[7:0];
            1: td1 = w[6:0];
            default: td2 = w[8:0];
        endcase
    endtask

    function automatic logic tick(int rate);
        return $urandom_range(0, rate - 1) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bt = tick(2);
            step();
            for (int j = 0; j < 3; j++) begin
                check($sformatf("u%0d_idle_tx", j), txo[j], 1);
                check($sformatf("u%0d_idle_ready", j), rdy[j], 1);
                check($sformatf("u%0d_idle_busy", j), bsy[j], 0);
            end
        end
    endtask

    // Sends word w on instance k; if abort_idx >= 0, pulses rst once frame bit abort_idx is on the line.
    task automatic send(int k, int w, int rate, int abort_idx);
        bit fr[$];
        int ones, n, cyc, idx, len;
        check($sformatf("u%0d_ready_pre", k), rdy[k], 1);
        set_in(k, 1'b1, w);
        bt = tick(rate);
        step();
        fr.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < db[k]; i++) begin
            fr.push_back(bit'((w >> i) & 1));
            ones += (w >> i) & 1;
        end
        if (pm[k] == 1) fr.push_back(bit'(ones % 2));
        if (pm[k] == 2) fr.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < sb[k]; i++) fr.push_back(1'b1);
        len = fr.size();
        n = 0;
        cyc = 0;
        while (cyc < 20000) begin
            idx = n / os[k];
            check($sformatf("u%0d_tx", k), txo[k], idx < len ? int'(fr[idx]) : 1);
            check($sformatf("u%0d_ready", k), rdy[k], int'(n >= os[k] * len));
            check($sformatf("u%0d_busy", k), bsy[k], int'(n < os[k] * len));
            if (n >= os[k] * len) break;
            if (idx == abort_idx) begin
                rst = 1'b1;
                set_in(k, 1'b0, 0);
                step();
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("u%0d_rst_tx", j), txo[j], 1);
                    check($sformatf("u%0d_rst_busy", j), bsy[j], 0);
                    check($sformatf("u%0d_rst_ready", j), rdy[j], 0);
                end
                rst = 1'b0;
                step();
                for (int j = 0; j < 3; j++) check($sformatf("u%0d_post_rst_ready", j), rdy[j], 1);
                return;
            end
            set_in(k, logic'($urandom_range(0, 1)), int'($urandom));
            bt = tick(rate);
            step();
            cyc++;
            if (bt) n++;
        end
        if (n < os[k] * len) check($sformatf("u%0d_frame_timeout", k), n, os[k] * len);
        else if (rate == 1) check($sformatf("u%0d_frame_len", k), cyc, os[k] * len);
        set_in(k, 1'b0, int'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        bt  = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        for (int j = 0; j < 3; j++) set_in(j, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("u%0d_reset_tx", j), txo[j], 1);
            check($sformatf("u%0d_reset_ready", j), rdy[j], 0);
            check($sformatf("u%0d_reset_busy", j), bsy[j], 0);
        end
        rst = 1'b0;
        step();
        for (int j = 0; j < 3; j++) check($sformatf("u%0d_ready_after_reset", j), rdy[j], 1);
        send(0, 'hA5, 1, -1);
        send(1, 'h07, 1, -1);
        send(2, 'h07, 1, -1);
        send(1, 'h55, 4, -1);
        idle(2);
        send(0, 'h3C, 2, -1);
        send(0, 'hC3, 2, -1);
        idle(1);
        send(0, 'h5A, 1, 4);
        send(0, 'h81, 1, -1);
        repeat (12) begin
            send(int'($urandom_range(0, 2)), int'($urandom), int'($urandom_range(1, 4)), -1);
            idle(int'($urandom_range(0, 3)));
        end
`ifdef UART_TX_BREAK_EN
        brk = 1'b1;
        bt  = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            check("brk_tx_low", txo[0], 0);
            check("brk_ready_low", rdy[0], 0);
        end
        brk = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            check("brk_rec_tx", txo[0], 1);
            check("brk_rec_ready", rdy[0], 0);
        end
        step();
        check("brk_done_ready", rdy[0], 1);
        send(0, 'h96, 1, -1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
